// File: rtl/p405s_pfb_predecode_fifo.sv
// Prefetch-buffer FIFO that classifies each fetched word as b/bc/bclr/bcctr on entry.
// Optional macro PFB_PREDECODE_BCCTR_EN enables bcctr classification and its storage bit.
module p405s_pfb_predecode_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CB,
    input  logic             resetN,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [0:31]      inInstr,
    input  logic [TAG_W-1:0] inTag,
    output logic             outValid,
    input  logic             outReady,
    output logic [0:31]      outInstr,
    output logic [TAG_W-1:0] outTag,
    output logic             outIsB,
    output logic             outIsBc,
    output logic             outIsBclr,
    output logic             outIsBcctr,
    output logic             outLk,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [0:31]      instr_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic             is_b_q    [DEPTH];
    logic             is_bc_q   [DEPTH];
    logic             is_bclr_q [DEPTH];
    logic             lk_q      [DEPTH];
`ifdef PFB_PREDECODE_BCCTR_EN
    logic             is_bcctr_q [DEPTH];
`endif

    // Predecode on the incoming word, IBM bit numbering (bit 0 = MSB)
    logic [5:0] opcd;
    logic [9:0] xo;
    logic       dec_b, dec_bc, dec_bclr, dec_bcctr, dec_lk;

    always_comb begin
        opcd     = inInstr[0:5];
        xo       = inInstr[21:30];
        dec_b    = (opcd == 6'd18);
        dec_bc   = (opcd == 6'd16);
        dec_bclr = (opcd == 6'd19) && (xo == 10'd16);
`ifdef PFB_PREDECODE_BCCTR_EN
        dec_bcctr = (opcd == 6'd19) && (xo == 10'd528);
`else
        dec_bcctr = 1'b0;
`endif
        dec_lk   = inInstr[31] & (dec_b | dec_bc | dec_bclr | dec_bcctr);
    end

    logic push, pop;

    always_comb begin
        inReady  = (count_q != CNT_W'(DEPTH));
        outValid = (count_q != '0);
        push     = inValid & inReady & ~flush;
        pop      = outValid & outReady & ~flush;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge CB) begin
        if (!resetN) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is written only on an accepted push, so junk on inInstr never lands in state
    always_ff @(posedge CB) begin
        if (resetN && push) begin
            instr_q[wr_ptr_q]   <= inInstr;
            tag_q[wr_ptr_q]     <= inTag;
            is_b_q[wr_ptr_q]    <= dec_b;
            is_bc_q[wr_ptr_q]   <= dec_bc;
            is_bclr_q[wr_ptr_q] <= dec_bclr;
            lk_q[wr_ptr_q]      <= dec_lk;
`ifdef PFB_PREDECODE_BCCTR_EN
            is_bcctr_q[wr_ptr_q] <= dec_bcctr;
`endif
        end
    end

    always_comb begin
        outInstr   = '0;
        outTag     = '0;
        outIsB     = 1'b0;
        outIsBc    = 1'b0;
        outIsBclr  = 1'b0;
        outIsBcctr = 1'b0;
        outLk      = 1'b0;
        if (outValid) begin
            outInstr  = instr_q[rd_ptr_q];
            outTag    = tag_q[rd_ptr_q];
            outIsB    = is_b_q[rd_ptr_q];
            outIsBc   = is_bc_q[rd_ptr_q];
            outIsBclr = is_bclr_q[rd_ptr_q];
            outLk     = lk_q[rd_ptr_q];
`ifdef PFB_PREDECODE_BCCTR_EN
            outIsBcctr = is_bcctr_q[rd_ptr_q];
`endif
        end
    end

    assign count = count_q;

endmodule
